// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares one SDRAM controller port between the VGA display fetch path
//   (read-only, latency critical) and the host port (read or write). VGA has
//   fixed priority; a streak counter lets the host in after MAX_VGA_STREAK
//   consecutive VGA grants while the host is waiting. A per-transaction
//   watchdog aborts a grant that the SDRAM controller never acknowledges.
//
// Ports
//   iclk_50        in   system clock, rising edge
//   ireset         in   synchronous active-high reset
//   ivga_req       in   VGA read request, held until ovga_ack
//   ivga_address   in   VGA line address
//   ovga_data      out  VGA read line, valid with ovga_ack
//   ovga_ack       out  one-cycle VGA completion pulse
//   ihost_req      in   host request, held until ohost_ack
//   ihost_we       in   host op: 1 = write, 0 = read
//   ihost_address  in   host line address
//   ihost_wdata    in   host write line
//   ohost_rdata    out  host read line, valid with ohost_ack
//   ohost_ack      out  one-cycle host completion pulse
//   oread_req      out  SDRAM read request
//   owrite_req     out  SDRAM write request
//   oaddress       out  SDRAM line address
//   owrite_data    out  SDRAM write line
//   iread_data     in   SDRAM read line, valid with iread_ack
//   iread_ack      in   SDRAM read complete
//   iwrite_ack     in   SDRAM write complete
//   otimeout       out  sticky flag: some transaction was aborted
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no transaction; arbitrate between pending requests
// GRANT  | SDRAM request held; waiting for matching ack or watchdog
// DONE   | owner's ack pulse is high; back to IDLE next edge

module sdram_port_arbiter #(
  parameter int ADDR_W         = 22,
  parameter int DATA_W         = 128,
  parameter int MAX_VGA_STREAK = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              iclk_50,
  input  logic              ireset,
  input  logic              ivga_req,
  input  logic [ADDR_W-1:0] ivga_address,
  output logic [DATA_W-1:0] ovga_data,
  output logic              ovga_ack,
  input  logic              ihost_req,
  input  logic              ihost_we,
  input  logic [ADDR_W-1:0] ihost_address,
  input  logic [DATA_W-1:0] ihost_wdata,
  output logic [DATA_W-1:0] ohost_rdata,
  output logic              ohost_ack,
  output logic              oread_req,
  output logic              owrite_req,
  output logic [ADDR_W-1:0] oaddress,
  output logic [DATA_W-1:0] owrite_data,
  input  logic [DATA_W-1:0] iread_data,
  input  logic              iread_ack,
  input  logic              iwrite_ack,
  output logic              otimeout
);

  localparam int STREAK_W = $clog2(MAX_VGA_STREAK + 1);
  localparam int TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Watchdog is a down-counter loaded so that terminal count (zero) is
  // reached on the TIMEOUT_CYCLES-th GRANT edge.
  localparam logic [TMO_W-1:0]    TMO_LOAD   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VGA_STREAK);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_DONE
  } state_t;

  state_t              state;
  logic                owner_host;
  logic                op_write;
  logic [STREAK_W-1:0] streak;
  logic [TMO_W-1:0]    tmo_cnt;

  logic streak_full;
  logic host_win;
  logic vga_win;
  logic xfer_done;
  logic tmo_hit;

  assign streak_full = (streak == STREAK_MAX);
  assign host_win    = ihost_req && (!ivga_req || streak_full);
  assign vga_win     = ivga_req && !host_win;
  // Only the ack matching the issued operation completes it.
  assign xfer_done   = op_write ? iwrite_ack : iread_ack;
  assign tmo_hit     = (tmo_cnt == '0);

  always_ff @(posedge iclk_50) begin
    if (ireset) begin
      state       <= ST_IDLE;
      owner_host  <= 1'b0;
      op_write    <= 1'b0;
      streak      <= '0;
      tmo_cnt     <= '0;
      ovga_data   <= '0;
      ovga_ack    <= 1'b0;
      ohost_rdata <= '0;
      ohost_ack   <= 1'b0;
      oread_req   <= 1'b0;
      owrite_req  <= 1'b0;
      oaddress    <= '0;
      owrite_data <= '0;
      otimeout    <= 1'b0;
    end else begin
      ovga_ack  <= 1'b0;
      ohost_ack <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!ihost_req) begin
            streak <= '0;
          end
          if (host_win) begin
            owner_host <= 1'b1;
            op_write   <= ihost_we;
            oaddress   <= ihost_address;
            if (ihost_we) begin
              owrite_data <= ihost_wdata;
            end
            oread_req  <= !ihost_we;
            owrite_req <= ihost_we;
            streak     <= '0;
            tmo_cnt    <= TMO_LOAD;
            state      <= ST_GRANT;
          end else if (vga_win) begin
            owner_host <= 1'b0;
            op_write   <= 1'b0;
            oaddress   <= ivga_address;
            oread_req  <= 1'b1;
            owrite_req <= 1'b0;
            if (ihost_req && !streak_full) begin
              streak <= streak + STREAK_W'(1);
            end
            tmo_cnt    <= TMO_LOAD;
            state      <= ST_GRANT;
          end
        end

        ST_GRANT: begin
          if (xfer_done) begin
            oread_req  <= 1'b0;
            owrite_req <= 1'b0;
            // A completed write leaves the host read bus untouched.
            if (!op_write) begin
              if (owner_host) begin
                ohost_rdata <= iread_data;
              end else begin
                ovga_data <= iread_data;
              end
            end
            ohost_ack <= owner_host;
            ovga_ack  <= !owner_host;
            state     <= ST_DONE;
          end else if (tmo_hit) begin
            oread_req  <= 1'b0;
            owrite_req <= 1'b0;
            if (owner_host) begin
              ohost_rdata <= '0;
            end else begin
              ovga_data <= '0;
            end
            otimeout  <= 1'b1;
            ohost_ack <= owner_host;
            ovga_ack  <= !owner_host;
            state     <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
